// File: rtl/dds_pkt_pkg.sv
// Shared constants, FSM state encoding and the decoded command record for the
// DDS command packet parser.
package dds_pkt_pkg;

    localparam logic [7:0]  PKT_HDR     = 8'h55;
    localparam logic [7:0]  PKT_FTR     = 8'hAA;
    localparam int unsigned PAYLOAD_LEN = 11;
    localparam logic [7:0]  CRC_POLY    = 8'h07;
    localparam logic [3:0]  LAST_IDX    = 4'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC,
        FOOTER
    } state_t;

    typedef struct packed {
        logic [7:0]  func;
        logic [7:0]  ch;
        logic [7:0]  sta;
        logic [7:0]  duty;
        logic [15:0] dessert;
        logic [7:0]  pnum;
        logic [31:0] pat;
    } cmd_t;

    // Payload byte 0 is the first byte after the header.
    function automatic cmd_t unpack_payload(input logic [PAYLOAD_LEN-1:0][7:0] p);
        cmd_t c;
        c.func    = p[0];
        c.ch      = p[1];
        c.sta     = p[2];
        c.duty    = p[3];
        c.dessert = {p[4], p[5]};
        c.pnum    = p[6];
        c.pat     = {p[7], p[8], p[9], p[10]};
        return c;
    endfunction

endpackage

// File: rtl/crc8_step.sv
// One-byte CRC-8 update (poly 0x07, MSB first, no reflection), purely
// combinational so the parser can fold a byte per rx_done.
module crc8_step
    import dds_pkt_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_next_crc
);

    logic [7:0] w_acc;

    always_comb begin
        w_acc = i_crc ^ i_byte;
        for (int k = 0; k < 8; k++) begin
            if (w_acc[7]) begin
                w_acc = {w_acc[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_acc = {w_acc[6:0], 1'b0};
            end
        end
        o_next_crc = w_acc;
    end

endmodule

// File: rtl/dds_pkt_parser.sv
// UART packet parser for DDS commands: 0x55, 11 payload bytes, CRC-8, 0xAA.
// Define PKT_STAT_EN to add saturating good/bad packet counters.
module dds_pkt_parser
    import dds_pkt_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TIMEOUT_CYC = 50_000
)(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        cmd_valid,
    output logic [7:0]  cmd_func,
    output logic [7:0]  cmd_ch,
    output logic [7:0]  cmd_sta,
    output logic [7:0]  cmd_duty,
    output logic [7:0]  cmd_pnum,
    output logic [15:0] cmd_dessert,
    output logic [31:0] cmd_pat,
    output logic        crc_err,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy
`ifdef PKT_STAT_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    if (CLK_FREQ < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dds_pkt_parser: CLK_FREQ and TIMEOUT_CYC must be positive");
    end

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [3:0]                     r_idx;
    logic [7:0]                     r_crc;
    logic                           r_crc_ok;
    logic [PAYLOAD_LEN-1:0][7:0]    r_buf;
    logic [TW-1:0]                  r_tmo_cnt;
    cmd_t                           r_cmd;
    logic                           r_cmd_valid;
    logic                           r_crc_err;
    logic                           r_frame_err;
    logic                           r_tmo_err;
    logic                           w_valid_nxt;
    logic                           w_crc_err_nxt;
    logic                           w_frame_err_nxt;
    logic                           w_tmo_hit;
    logic [7:0]                     w_crc_step;

    crc8_step u_crc8_step (
        .i_crc      (r_crc),
        .i_byte     (rx_data),
        .o_next_crc (w_crc_step)
    );

    // This cycle is the TIMEOUT_CYC-th consecutive one without a byte.
    assign w_tmo_hit = (r_state != IDLE) && !rx_done && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = 1'b0;
        w_crc_err_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        if (w_tmo_hit) begin
            w_state_nxt = IDLE;
        end else if (rx_done) begin
            case (r_state)
                IDLE:    if (rx_data == PKT_HDR) w_state_nxt = PAYLOAD;
                PAYLOAD: if (r_idx == LAST_IDX) w_state_nxt = CRC;
                CRC:     w_state_nxt = FOOTER;
                FOOTER: begin
                    w_state_nxt = IDLE;
                    if (rx_data != PKT_FTR) begin
                        w_frame_err_nxt = 1'b1;
                    end else if (r_crc_ok) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_crc_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_crc       <= '0;
            r_crc_ok    <= 1'b0;
            r_buf       <= '0;
            r_tmo_cnt   <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_tmo_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= w_valid_nxt;
            r_crc_err   <= w_crc_err_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_tmo_err   <= w_tmo_hit;

            if (r_state == IDLE || rx_done || w_tmo_hit) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end

            if (rx_done) begin
                case (r_state)
                    IDLE: begin
                        if (rx_data == PKT_HDR) begin
                            r_idx <= '0;
                            r_crc <= '0;
                        end
                    end
                    PAYLOAD: begin
                        r_buf[r_idx] <= rx_data;
                        r_idx        <= r_idx + 4'd1;
                        r_crc        <= w_crc_step;
                    end
                    CRC:     r_crc_ok <= (rx_data == r_crc);
                    default: ;
                endcase
            end

            // Only an accepted packet may replace the held command fields.
            if (w_valid_nxt) begin
                r_cmd <= unpack_payload(r_buf);
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_func    = r_cmd.func;
    assign cmd_ch      = r_cmd.ch;
    assign cmd_sta     = r_cmd.sta;
    assign cmd_duty    = r_cmd.duty;
    assign cmd_pnum    = r_cmd.pnum;
    assign cmd_dessert = r_cmd.dessert;
    assign cmd_pat     = r_cmd.pat;
    assign crc_err     = r_crc_err;
    assign frame_err   = r_frame_err;
    assign timeout_err = r_tmo_err;
    assign busy        = (r_state != IDLE);

`ifdef PKT_STAT_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if (r_cmd_valid && r_good_cnt != 16'hFFFF) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if ((r_crc_err || r_frame_err || r_tmo_err) && r_bad_cnt != 16'hFFFF) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_dds_pkt_parser.sv
// Self-checking bench for dds_pkt_parser: directed packets plus random traffic
// against a byte-queue model of the packet format.
module tb_dds_pkt_parser;

    localparam int TIMEOUT = 40;
    localparam logic [87:0] PKT_A = {8'h02, 8'h01, 8'h01, 64'h0};
    localparam logic [87:0] PKT_C = 88'h13_07_01_40_12_34_05_DE_AD_BE_EF;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        cmd_valid;
    logic [7:0]  cmd_func, cmd_ch, cmd_sta, cmd_duty, cmd_pnum;
    logic [15:0] cmd_dessert;
    logic [31:0] cmd_pat;
    logic        crc_err, frame_err, timeout_err, busy;
`ifdef PKT_STAT_EN
    logic [15:0] good_cnt, bad_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic checkEn = 1'b0;

    int nValid = 0, nCrc = 0, nFrame = 0, nTmo = 0;
    int mValid = 0, mCrc = 0, mFrame = 0, mTmo = 0;

    dds_pkt_parser #(
        .CLK_FREQ    (50_000_000),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .cmd_valid   (cmd_valid),
        .cmd_func    (cmd_func),
        .cmd_ch      (cmd_ch),
        .cmd_sta     (cmd_sta),
        .cmd_duty    (cmd_duty),
        .cmd_pnum    (cmd_pnum),
        .cmd_dessert (cmd_dessert),
        .cmd_pat     (cmd_pat),
        .crc_err     (crc_err),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy        (busy)
`ifdef PKT_STAT_EN
        ,
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Bit-serial long division of the whole 88-bit payload by x^8+x^2+x+1.
    function automatic logic [7:0] modelCrc(input logic [87:0] msg);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 87; i >= 0; i--) begin
            fb = c[7] ^ msg[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int gap);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic sendPacket(input logic [87:0] payload, input logic [7:0] crcXor,
                              input logic [7:0] footer, input int maxGap);
        logic [7:0] crcByte;
        crcByte = modelCrc(payload) ^ crcXor;
        applyStimulus(8'h55, int'($urandom_range(maxGap, 0)));
        for (int i = 10; i >= 0; i--) begin
            applyStimulus(payload[i*8 +: 8], int'($urandom_range(maxGap, 0)));
        end
        applyStimulus(crcByte, int'($urandom_range(maxGap, 0)));
        applyStimulus(footer, int'($urandom_range(maxGap, 0)));
    endtask

    // Reference model: bytes after a header are queued until 13 have arrived.
    logic        mInPkt;
    int          mGap;
    logic [7:0]  mPkt[$];
    logic        eValid, eCrc, eFrame, eTmo;
    logic [87:0] eCmd;
    logic [15:0] eGood, eBad;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            mInPkt = 1'b0;
            mGap   = 0;
            mPkt.delete();
            eValid = 1'b0; eCrc = 1'b0; eFrame = 1'b0; eTmo = 1'b0;
            eCmd   = '0;
            eGood  = '0;
            eBad   = '0;
        end else begin
            if (eValid && eGood != 16'hFFFF) eGood = eGood + 16'd1;
            if ((eCrc || eFrame || eTmo) && eBad != 16'hFFFF) eBad = eBad + 16'd1;
            eValid = 1'b0; eCrc = 1'b0; eFrame = 1'b0; eTmo = 1'b0;
            if (mInPkt && !rx_done) begin
                mGap++;
                if (mGap == TIMEOUT) begin
                    eTmo = 1'b1;
                    mInPkt = 1'b0;
                    mTmo++;
                end
            end else if (rx_done) begin
                mGap = 0;
                if (!mInPkt) begin
                    if (rx_data == 8'h55) begin
                        mInPkt = 1'b1;
                        mPkt.delete();
                    end
                end else begin
                    mPkt.push_back(rx_data);
                    if (mPkt.size() == 13) begin
                        logic [87:0] pl;
                        mInPkt = 1'b0;
                        for (int i = 0; i < 11; i++) pl[(10-i)*8 +: 8] = mPkt[i];
                        if (mPkt[12] != 8'hAA) begin
                            eFrame = 1'b1; mFrame++;
                        end else if (mPkt[11] == modelCrc(pl)) begin
                            eValid = 1'b1; mValid++;
                            eCmd = pl;
                        end else begin
                            eCrc = 1'b1; mCrc++;
                        end
                    end
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (checkEn) begin
            checkOutput("strobes", 128'({cmd_valid, crc_err, frame_err, timeout_err}),
                        128'({eValid, eCrc, eFrame, eTmo}));
            checkOutput("exclusive", 128'($countones({cmd_valid, crc_err, frame_err, timeout_err}) <= 1), 128'(1));
            checkOutput("busy", 128'(busy), 128'(mInPkt));
            checkOutput("cmd", 128'({cmd_func, cmd_ch, cmd_sta, cmd_duty, cmd_dessert, cmd_pnum, cmd_pat}),
                        128'(eCmd));
`ifdef PKT_STAT_EN
            checkOutput("good_cnt", 128'(good_cnt), 128'(eGood));
            checkOutput("bad_cnt", 128'(bad_cnt), 128'(eBad));
`endif
            if (cmd_valid === 1'b1) nValid++;
            if (crc_err === 1'b1) nCrc++;
            if (frame_err === 1'b1) nFrame++;
            if (timeout_err === 1'b1) nTmo++;
        end
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int v0, c0, f0, t0, e0;
        logic [87:0] pl;
        logic [7:0]  b;
        int mode, k;

        sys_rst = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge sys_clk);
        checkEn = 1'b1;
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_strobes", 128'({cmd_valid, crc_err, frame_err, timeout_err}), 128'(0));
        checkOutput("reset_cmd", 128'({cmd_func, cmd_ch, cmd_sta, cmd_duty, cmd_dessert, cmd_pnum, cmd_pat}), 128'(0));
        sys_rst = 1'b0;
        @(negedge sys_clk);

        checkOutput("model_crc_pin", 128'(modelCrc(PKT_A)), 128'(8'h2F));

        v0 = nValid; e0 = nCrc + nFrame + nTmo;
        sendPacket(PKT_A, 8'h00, 8'hAA, 2);
        repeat (3) @(negedge sys_clk);
        checkOutput("good_valid_count", 128'(nValid - v0), 128'(1));
        checkOutput("good_err_count", 128'(nCrc + nFrame + nTmo - e0), 128'(0));
        checkOutput("good_func", 128'(cmd_func), 128'(8'h02));
        checkOutput("good_ch_sta", 128'({cmd_ch, cmd_sta}), 128'(16'h0101));
        checkOutput("good_dessert_pat", 128'({cmd_dessert, cmd_pat}), 128'(48'h0));

        sendPacket(PKT_C, 8'h00, 8'hAA, 1);
        repeat (3) @(negedge sys_clk);
        checkOutput("c_pat", 128'(cmd_pat), 128'(32'hDEADBEEF));
        checkOutput("c_dessert", 128'(cmd_dessert), 128'(16'h1234));

        v0 = nValid; c0 = nCrc;
        sendPacket(PKT_A, 8'h01, 8'hAA, 1);
        repeat (3) @(negedge sys_clk);
        checkOutput("crcerr_count", 128'(nCrc - c0), 128'(1));
        checkOutput("crcerr_no_valid", 128'(nValid - v0), 128'(0));
        checkOutput("crcerr_keeps_cmd", 128'(cmd_func), 128'(8'h13));

        v0 = nValid; f0 = nFrame;
        sendPacket(PKT_A, 8'h00, 8'hAB, 1);
        repeat (3) @(negedge sys_clk);
        checkOutput("frame_count", 128'(nFrame - f0), 128'(1));
        checkOutput("frame_no_valid", 128'(nValid - v0), 128'(0));
        sendPacket(PKT_A, 8'h00, 8'hAA, 1);
        repeat (3) @(negedge sys_clk);
        checkOutput("after_frame_valid", 128'(nValid - v0), 128'(1));
        checkOutput("after_frame_func", 128'(cmd_func), 128'(8'h02));

        v0 = nValid; e0 = nCrc + nFrame + nTmo;
        applyStimulus(8'h00, 0);
        applyStimulus(8'hFF, 1);
        applyStimulus(8'h12, 2);
        checkOutput("garbage_idle", 128'(busy), 128'(0));
        sendPacket(PKT_C, 8'h00, 8'hAA, 0);
        repeat (3) @(negedge sys_clk);
        checkOutput("garbage_valid", 128'(nValid - v0), 128'(1));
        checkOutput("garbage_errs", 128'(nCrc + nFrame + nTmo - e0), 128'(0));

        t0 = nTmo; v0 = nValid;
        applyStimulus(8'h55, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h01, 0);
        checkOutput("tmo_busy_before", 128'(busy), 128'(1));
        repeat (TIMEOUT + 5) @(negedge sys_clk);
        checkOutput("tmo_count", 128'(nTmo - t0), 128'(1));
        checkOutput("tmo_busy_after", 128'(busy), 128'(0));
        sendPacket(PKT_A, 8'h00, 8'hAA, 2);
        repeat (3) @(negedge sys_clk);
        checkOutput("tmo_recover_valid", 128'(nValid - v0), 128'(1));

        v0 = nValid; e0 = nCrc + nFrame + nTmo;
        applyStimulus(8'h55, 0);
        for (int i = 10; i >= 6; i--) applyStimulus(PKT_C[i*8 +: 8], 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        checkOutput("rst_mid_busy", 128'(busy), 128'(0));
        checkOutput("rst_mid_strobes", 128'(nValid + nCrc + nFrame + nTmo - v0 - e0), 128'(0));
        sendPacket(PKT_A, 8'h00, 8'hAA, 1);
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_mid_valid", 128'(nValid - v0), 128'(1));
`ifdef PKT_STAT_EN
        checkOutput("rst_mid_good_cnt", 128'(good_cnt), 128'(1));
`endif

        for (int n = 0; n < 150; n++) begin
            pl = 88'({$urandom, $urandom, $urandom});
            mode = int'($urandom_range(9, 0));
            case (mode)
                5: sendPacket(pl, 8'($urandom_range(255, 1)), 8'hAA, 3);
                6: begin
                    b = 8'($urandom);
                    if (b == 8'hAA) b = 8'hAB;
                    sendPacket(pl, ($urandom_range(1, 0) == 1) ? 8'h5A : 8'h00, b, 3);
                end
                7: begin
                    applyStimulus(8'h55, 1);
                    k = int'($urandom_range(12, 0));
                    for (int j = 0; j < k; j++) applyStimulus(8'($urandom), 1);
                    repeat (TIMEOUT + 3) @(negedge sys_clk);
                end
                8: begin
                    k = int'($urandom_range(4, 1));
                    for (int j = 0; j < k; j++) begin
                        b = 8'($urandom);
                        if (b == 8'h55) b = 8'h56;
                        applyStimulus(b, int'($urandom_range(2, 0)));
                    end
                    sendPacket(pl, 8'h00, 8'hAA, 3);
                end
                9: begin
                    for (int j = 0; j < 11; j++) begin
                        if ($urandom_range(2, 0) == 0) pl[j*8 +: 8] = 8'h55;
                    end
                    sendPacket(pl, 8'h00, 8'hAA, 3);
                end
                default: sendPacket(pl, 8'h00, 8'hAA, 3);
            endcase
        end
        repeat (TIMEOUT + 5) @(negedge sys_clk);

        checkOutput("total_valid", 128'(nValid), 128'(mValid));
        checkOutput("total_crc_err", 128'(nCrc), 128'(mCrc));
        checkOutput("total_frame_err", 128'(nFrame), 128'(mFrame));
        checkOutput("total_timeout_err", 128'(nTmo), 128'(mTmo));

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_pkt_parser.md
DDS_PKT_PARSER -- requirements
Module: dds_pkt_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50_000 (1 ms), meaning the maximum idle cycles allowed between bytes inside a packet.
REQ-003 sys_clk  in  1  the only clock; all logic rises on it.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 rx_data  in  8  byte from the UART receiver, valid while rx_done=1.
REQ-006 rx_done  in  1  single-cycle strobe, one per received byte.
REQ-007 cmd_valid  out  1  single-cycle strobe, decoded command fields valid.
REQ-008 cmd_func, cmd_ch, cmd_sta, cmd_duty, cmd_pnum  out  8 each  reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num and pulse_num fields.
REQ-009 cmd_dessert  out  16  {pulse_dessert_h, pulse_dessert_l}.
REQ-010 cmd_pat  out  32  {pat1, pat2, pat3, pat4}, with pat1 in the MSB position.
REQ-011 crc_err, frame_err, timeout_err  out  1 each  single-cycle error strobes.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The packet SHALL be 14 bytes: 0x55, 11 payload bytes (func, ch, sta, duty, pd_h, pd_l, pnum, pat1..pat4), CRC, 0xAA.
REQ-014 The CRC SHALL be CRC-8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, computed over the 11 payload bytes only.
REQ-015 The FSM SHALL have states IDLE, PAYLOAD, CRC, FOOTER, all transitions qualified by rx_done.
REQ-016 IDLE: a byte of 0x55 SHALL go to PAYLOAD, clear the byte index and seed the CRC at 0x00; any other byte SHALL be silently discarded.
REQ-017 PAYLOAD: each byte SHALL be stored at the current index and folded into the CRC; after index 10, the FSM SHALL go to CRC.
REQ-018 CRC: the received byte SHALL be compared against the computed CRC, the result latched, and the FSM SHALL go to FOOTER.
REQ-019 FOOTER, byte == 0xAA with CRC match: cmd_valid SHALL pulse exactly 1 cycle after this rx_done, and all cmd_* SHALL update in that same cycle.
REQ-020 FOOTER, byte == 0xAA with CRC mismatch: crc_err SHALL pulse; cmd_valid SHALL stay low.
REQ-021 FOOTER, byte != 0xAA: frame_err SHALL pulse, whatever the CRC result; cmd_valid SHALL stay low.
REQ-022 After FOOTER, every case SHALL return to IDLE.
REQ-023 0x55 bytes inside the payload SHALL be treated as data, never as a resync.
REQ-024 Timeout: in any non-IDLE state, TIMEOUT_CYC consecutive cycles without rx_done SHALL pulse timeout_err and force IDLE. The counter SHALL clear on each rx_done.
REQ-025 cmd_* SHALL hold their last valid values until the next good packet; a rejected packet SHALL never alter them.
REQ-026 Error strobes and cmd_valid SHALL be mutually exclusive in every cycle.

Reset
REQ-027 While sys_rst=1 on a clock edge: FSM = IDLE; index, CRC and timeout counter = 0; all cmd_* = 0; all strobes = 0; busy = 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without raising any error strobe.

Configuration
REQ-029 With PKT_STAT_EN defined: outputs good_cnt and bad_cnt (16 bits each, saturating) SHALL exist. good_cnt SHALL count cmd_valid; bad_cnt SHALL count crc_err, frame_err and timeout_err. Both SHALL clear on reset.
REQ-030 Without PKT_STAT_EN: those ports and their counters SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-031 Package dds_pkt_pkg SHALL hold PKT_HDR = 8'h55, PKT_FTR = 8'hAA, PAYLOAD_LEN = 11, CRC_POLY = 8'h07, the FSM state enum and a packed cmd_t struct.
REQ-032 Sub-module crc8_step SHALL be combinational: next_crc = f(crc, byte), one byte per call.

Verification
REQ-033 Good packet 55 02 01 01 00x8 2F AA -> one cmd_valid with func=02, ch=01, sta=01, dessert=0000, pat=00000000; no error strobes.
REQ-034 The same packet with CRC byte 2E -> crc_err pulses once; cmd_valid stays low; cmd_* keep their previous values.
REQ-035 Good payload with footer 0xAB -> frame_err pulses once; the following good packet is accepted normally.
REQ-036 Garbage bytes 00 FF 12 before a good packet -> those bytes are ignored, then exactly one cmd_valid.
REQ-037 55 02 01 followed by silence longer than TIMEOUT_CYC -> timeout_err pulses once, busy drops, and a subsequent good packet is accepted.
REQ-038 sys_rst pulsed after byte 6 of a packet -> no strobes; the next good packet yields cmd_valid (with PKT_STAT_EN defined, good_cnt = 1).
